// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: default parameters and counter sizing shared by the debounce array.
package key_debounce_pkg;
   localparam int DEF_N_CH          = 4;
   localparam int DEF_DB_CYCLES     = 10000000;
   localparam int DEF_HOLD_CYCLES   = 50000000;
   localparam int DEF_REPEAT_CYCLES = 10000000;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: synchronizer, debouncer and optional auto-repeat for one channel.
// Auto-repeat is built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CW            = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)
) (
   input  logic clk,
   input  logic rstn,
   input  logic x_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic rpt_o
);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, press_q, press_d, rel_q, rel_d, flip, s;

   assign s = sync_q[1];

   // The count never passes DB_CYCLES-1: that is the cycle the level flips.
   always_comb begin
      flip    = (s != level_q) && (cnt_q == CW'(DB_CYCLES - 1));
      cnt_d   = ((s == level_q) || flip) ? '0 : cnt_q + 1'b1;
      level_d = level_q ^ flip;
      press_d = flip & ~level_q;
      rel_d   = flip & level_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], x_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic          first_q, first_d, rpt_q, rpt_d, hit;

   // first_q selects the shorter inter-repeat period once the initial hold has elapsed.
   always_comb begin
      hit     = level_q & ~flip &
                (rcnt_q == (first_q ? CW'(REPEAT_CYCLES - 1) : CW'(HOLD_CYCLES - 1)));
      rcnt_d  = (~level_q | flip | hit) ? '0 : rcnt_q + 1'b1;
      first_d = level_q & ~flip & (first_q | hit);
      rpt_d   = hit;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rcnt_q  <= '0;
         first_q <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         rcnt_q  <= rcnt_d;
         first_q <= first_d;
         rpt_q   <= rpt_d;
      end
   end

   assign rpt_o = rpt_q;
`else
   assign rpt_o = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_array.sv
// key_debounce_array: N_CH independent debounced key channels with press/release/repeat pulses.
// Auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN; otherwise rpt_o is tied low.
module key_debounce_array
   import key_debounce_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N_CH-1:0] x_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] rpt_o
);
   localparam int CW = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      key_debounce_ch #(
         .DB_CYCLES    (DB_CYCLES),
         .HOLD_CYCLES  (HOLD_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .CW           (CW)
      ) u_ch (
         .clk      (clk),
         .rstn     (rstn),
         .x_i      (x_i[i]),
         .level_o  (level_o[i]),
         .press_o  (press_o[i]),
         .release_o(release_o[i]),
         .rpt_o    (rpt_o[i])
      );
   end
endmodule

// File: tb/tb_key_debounce_array.sv
// tb_key_debounce_array: directed and random checks of the debounce array against a cycle model.
module tb_key_debounce_array;
   localparam int N    = 4;
   localparam int DB   = 8;
   localparam int HOLD = 20;
   localparam int REP  = 10;
`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [N-1:0] x = '0;
   logic [N-1:0] level, press, rel, rpt;
   int           checks = 0;
   int           errors = 0;

   key_debounce_array #(
      .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rstn(rstn), .x_i(x),
      .level_o(level), .press_o(press), .release_o(rel), .rpt_o(rpt)
   );

   always #5 clk = ~clk;

   // Reference: the input seen two edges late must disagree with the level for DB
   // consecutive edges to be accepted; repeats fall at HOLD, HOLD+REP, ... edges after press.
   logic [N-1:0] xd1, xd2, m_level, m_press, m_rel, m_rpt;
   int           m_run[N];
   int           m_held[N];

   function automatic bit acc(int c);
      return (xd2[c] != m_level[c]) && (m_run[c] + 1 >= DB);
   endfunction

   function automatic bit rep_due(int c);
      int k;
      k = m_held[c] + 1;
      return REP_EN && m_level[c] && !acc(c) && k >= HOLD && ((k - HOLD) % REP == 0);
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         xd1 <= '0; xd2 <= '0; m_level <= '0; m_press <= '0; m_rel <= '0; m_rpt <= '0;
         for (int c = 0; c < N; c++) begin
            m_run[c]  <= 0;
            m_held[c] <= 0;
         end
      end else begin
         xd1 <= x;
         xd2 <= xd1;
         for (int c = 0; c < N; c++) begin
            m_run[c]   <= ((xd2[c] == m_level[c]) || acc(c)) ? 0 : m_run[c] + 1;
            m_level[c] <= m_level[c] ^ acc(c);
            m_press[c] <= acc(c) && !m_level[c];
            m_rel[c]   <= acc(c) && m_level[c];
            m_rpt[c]   <= rep_due(c);
            m_held[c]  <= (m_level[c] && !acc(c)) ? m_held[c] + 1 : 0;
         end
      end
   end

   task automatic settle(input int n);
      @(negedge clk);
      x = '0;
      repeat (n) @(posedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({level, press, rel, rpt} !== 16'h0) begin
         errors++;
         $display("FAIL reset_state got %h exp 0000", {level, press, rel, rpt});
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle e=%0d got %h exp 0000", e, {level, press, rel, rpt});
         end
      end
   endtask

   task automatic test_clean_step();
      int pe, np, nr;
      pe = -1; np = 0; nr = 0;
      @(negedge clk);
      x[0] = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL step_model e=%0d got %h exp %h", e, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
         if (press[0]) begin np++; pe = e; end
         if (rel[0]) nr++;
      end
      checks++;
      if (np != 1 || pe != 10) begin
         errors++;
         $display("FAIL clean_press count=%0d edge=%0d exp count=1 edge=10", np, pe);
      end
      checks++;
      if (nr != 0) begin
         errors++;
         $display("FAIL clean_release count=%0d exp 0", nr);
      end
      checks++;
      if (level[0] !== 1'b1) begin
         errors++;
         $display("FAIL clean_level got %b exp 1", level[0]);
      end
   endtask

   task automatic test_bounce();
      int np, pe;
      np = 0; pe = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (cyc % 3 == 0) x[2] = ~x[2];
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL bounce_model cyc=%0d got %h exp %h", cyc, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
         if (press[2] || rel[2]) np++;
      end
      checks++;
      if (np != 0) begin
         errors++;
         $display("FAIL bounce_quiet pulses=%0d exp 0", np);
      end
      np = 0;
      @(negedge clk);
      x[2] = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (press[2]) begin np++; pe = e; end
      end
      checks++;
      if (np != 1 || pe != 10) begin
         errors++;
         $display("FAIL bounce_press count=%0d edge=%0d exp count=1 edge=10", np, pe);
      end
   endtask

   task automatic test_simultaneous();
      int p1, p3, r1, r3;
      p1 = -1; p3 = -1; r1 = -1; r3 = -1;
      @(negedge clk);
      x[1] = 1'b1;
      x[3] = 1'b1;
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL simul_model e=%0d got %h exp %h", e, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
         if (press[1]) p1 = e;
         if (press[3]) p3 = e;
         if (rel[1]) r1 = e;
         if (rel[3]) r3 = e;
         if (e == 40) begin
            @(negedge clk);
            x[1] = 1'b0;
            x[3] = 1'b0;
         end
      end
      checks++;
      if (p1 != 10 || p3 != 10) begin
         errors++;
         $display("FAIL simul_press edges=%0d,%0d exp 10,10", p1, p3);
      end
      checks++;
      if (r1 != 50 || r3 != 50) begin
         errors++;
         $display("FAIL simul_release edges=%0d,%0d exp 50,50", r1, r3);
      end
   endtask

   task automatic test_reset_mid();
      int p0, p2;
      p0 = -1; p2 = -1;
      @(negedge clk);
      x[2] = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (level[2] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre level2=%b exp 1", level[2]);
      end
      @(negedge clk);
      x[0] = 1'b1;
      repeat (7) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      checks++;
      if ({level, press, rel, rpt} !== 16'h0) begin
         errors++;
         $display("FAIL rstmid_clear got %h exp 0000", {level, press, rel, rpt});
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL rstmid_model e=%0d got %h exp %h", e, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
         if (press[0]) p0 = e;
         if (press[2]) p2 = e;
      end
      checks++;
      if (p0 != 10 || p2 != 10) begin
         errors++;
         $display("FAIL rstmid_press edges=%0d,%0d exp 10,10", p0, p2);
      end
   endtask

   task automatic test_repeat();
      int got[$];
      int exp_q[$];
      int pe, re;
      pe = -1; re = -1;
      if (REP_EN) exp_q = '{30, 40, 50, 60};
      @(negedge clk);
      x[0] = 1'b1;
      for (int e = 1; e <= 90; e++) begin
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL repeat_model e=%0d got %h exp %h", e, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
         if (rpt[0]) got.push_back(e);
         if (press[0]) pe = e;
         if (rel[0]) re = e;
         if (e == 60) begin
            @(negedge clk);
            x[0] = 1'b0;
         end
      end
      checks++;
      if (pe != 10 || re != 70) begin
         errors++;
         $display("FAIL repeat_edges press=%0d release=%0d exp 10,70", pe, re);
      end
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL repeat_count got %0d exp %0d", got.size(), exp_q.size());
      end else begin
         foreach (got[i]) begin
            checks++;
            if (got[i] != exp_q[i]) begin
               errors++;
               $display("FAIL repeat_at idx=%0d got %0d exp %0d", i, got[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if ($urandom_range(0, 399) == 0) rstn = 1'b0;
         else rstn = 1'b1;
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 11) == 0) x[c] = ~x[c];
         @(posedge clk); #1;
         checks++;
         if ({level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
            errors++;
            $display("FAIL random_model cyc=%0d got %h exp %h", cyc, {level, press, rel, rpt},
                     {m_level, m_press, m_rel, m_rpt});
         end
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_step();
      settle(30);
      test_bounce();
      settle(30);
      test_simultaneous();
      settle(30);
      test_reset_mid();
      settle(30);
      test_repeat();
      settle(30);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of independent input channels, range 1..32.
REQ-002 SHALL provide parameter DB_CYCLES, default 10000000: consecutive stable samples required to accept a change, minimum 1.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 50000000: cycles of held-high level before the first repeat pulse, minimum 1.
REQ-004 SHALL provide parameter REPEAT_CYCLES, default 10000000: cycles between later repeat pulses, minimum 1.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port x, input, N_CH: raw asynchronous key/switch levels.
REQ-008 SHALL have port level, output, N_CH: debounced stable level per channel.
REQ-009 SHALL have port press, output, N_CH: one-cycle pulse on accepted 0->1 change.
REQ-010 SHALL have port release, output, N_CH: one-cycle pulse on accepted 1->0 change.
REQ-011 SHALL have port rpt, output, N_CH: one-cycle auto-repeat pulses while level held high.

Function
REQ-012 SHALL pass each x bit through a 2-flop synchronizer; the second-stage value is the sample s.
REQ-013 SHALL keep per channel a counter of width $clog2(max(DB_CYCLES,HOLD_CYCLES,REPEAT_CYCLES)+1), cleared whenever s equals level.
REQ-014 SHALL increment the counter each cycle s differs from level; on the cycle it would reach DB_CYCLES, level SHALL flip and the counter SHALL clear.
REQ-015 SHALL register press/release on the same edge level flips: a clean x step yields the pulse and new level DB_CYCLES+2 edges after the first edge sampling the new x.
REQ-016 SHALL never assert press and release together on one channel; pulses are exactly one cycle wide.
REQ-017 SHALL restart the count from zero on any bounce (s returning to level) before DB_CYCLES is reached; no partial credit.
REQ-018 SHALL process channels fully independently; simultaneous events on several channels produce pulses in the same cycle.
REQ-019 SHALL NOT wrap any counter; counters saturate at their terminal value.

Reset
REQ-020 SHALL on rstn low asynchronously clear synchronizers, counters, level, press, release, rpt to 0.
REQ-021 SHALL, after reset deasserts with x already high, treat it as a fresh change: press after the full REQ-015 latency.
REQ-022 SHALL abandon any debounce or repeat count in progress when reset asserts mid-operation.

Configuration
REQ-023 SHALL, with macro KEY_DEBOUNCE_REPEAT_EN defined, emit rpt[i] HOLD_CYCLES cycles after press[i], then every REPEAT_CYCLES while level[i] stays 1; release stops repeats immediately.
REQ-024 SHALL, without KEY_DEBOUNCE_REPEAT_EN, keep port rpt present, tie it to 0 and omit repeat counters.

Structure
REQ-025 SHALL place counter-width calculation function and default parameter constants in package key_debounce_pkg.
REQ-026 SHALL implement one channel in sub-module key_debounce_ch, instantiated N_CH times via generate.

Verification (N_CH=4, DB_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=10)
REQ-027 SHALL test clean step: x[0] 0->1 held 30 cycles -> level[0]=1 and single press[0] 10 edges after step, no release.
REQ-028 SHALL test bounce: x[2] toggling every 3 cycles for 30 cycles then high -> no pulse during bounce, one press[2] 10 edges after final rise.
REQ-029 SHALL test release and simultaneity: x[1], x[3] rise same cycle, fall 40 cycles later -> press[1],press[3] same cycle; release[1],release[3] same cycle 10 edges after fall.
REQ-030 SHALL test reset mid-count: rstn low while counter=5 -> all outputs 0 immediately; rstn high with x[0]=1 -> press[0] 10 edges later.
REQ-031 SHALL test repeat: macro defined, x[0] held 60 cycles -> rpt[0] at press+20,+30,+40,+50 then none after release; macro undefined -> rpt stays 0.
